icache_responder: RTL and testbench

- Instruction-side responder for the pipelined core.
- Returns a 32-bit instruction word for the fetch PC and raises ihit, the stall/valid qualifier consumed by the main decoder and fetch stage.
- Direct-mapped, read-only cache with whole-line refill from a simple request/valid memory port.
- Sits between the fetch PC register and the instruction memory.

---
 rtl/icache_responder_pkg.sv | 36 +++
 rtl/icache_tagram.sv | 60 ++++++
 rtl/icache_responder.sv | 213 +++++++++++++++++++++
 tb/tb_icache_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared types and helpers for the instruction cache responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, the NOP instruction constant, and the
// address-field width helpers derived from NUM_LINES / LINE_WORDS.
package icache_responder_pkg;

    // LOOKUP : serve hits combinationally, detect misses
    // REFILL : one outstanding line request to memory
    // FILL   : bubble cycle so the new line is read back from the arrays
    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        REFILL = 2'd1,
        FILL   = 2'd2
    } state_t;

    // addi x0, x0, 0 -- issued whenever ihit is low
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word-within-line offset field width (pc[OFF+1:2]).
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line index field width, directly above the offset field.
    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Everything above index and offset (pc[1:0] is never stored).
    function automatic int tag_bits(input int num_lines, input int line_words);
        return 32 - 2 - offset_bits(line_words) - index_bits(num_lines);
    endfunction

endpackage

// File: rtl/icache_tagram.sv
// Valid/tag/data storage for a direct-mapped read-only cache.
// Latency: read port is combinational; write and flush take effect at the next edge.
// Backpressure: none; writes and flushes are always accepted.
//
// Ports:
//   clk, reset            clock, async active-high reset (clears valid bits only)
//   i_rd_idx              line index to read
//   o_rd_vld/tag/line     valid bit, stored tag and full line for i_rd_idx
//   i_wr_en/idx/tag/line  whole-line write; sets the line's valid bit
//   i_flush               clear every valid bit at the next edge (wins over a write)
module icache_tagram
    import icache_responder_pkg::*;
#(
    parameter  int NUM_LINES  = 4,
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = index_bits(NUM_LINES),
    localparam int TAG_W      = tag_bits(NUM_LINES, LINE_WORDS),
    localparam int LINE_W     = 32 * LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_vld,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_line,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_line,
    input  logic              i_flush
);

    logic [NUM_LINES-1:0] r_vld;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    // Valid bits are the only reset state; tags and data are don't-care
    // until their valid bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else if (i_wr_en) begin
            r_vld[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_rd_vld  = r_vld[i_rd_idx];
    assign o_rd_tag  = r_tag[i_rd_idx];
    assign o_rd_line = r_data[i_rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Instruction-side responder: direct-mapped read-only cache with whole-line refill.
// Latency: hit is combinational from pc; miss in cycle N -> mem_req in N+1 -> mem_valid in M -> ihit at M+2.
// Backpressure: ihit=0 stalls fetch during REFILL/FILL; mem_req is held until the one-cycle mem_valid pulse.
//
// Ports:
//   clk, reset   clock, async active-high reset
//   pc           fetch address (pc[1:0] ignored)
//   flush        one-cycle pulse invalidating every line (fence.i)
//   ihit, instr  instruction valid qualifier and word (NOP when ihit=0)
//   mem_req      refill request, held until mem_valid
//   mem_addr     line-aligned refill address, stable while mem_req=1
//   mem_valid    one-cycle pulse, mem_rdata carries the full line (word 0 in LSBs)
//   hit_count, miss_count  saturating statistics, present only with ICACHE_STATS_EN
//
// Optional feature macro: ICACHE_STATS_EN.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int          NUM_LINES  = 4,
    parameter int          LINE_WORDS = 4,
    // Reset vector of the core; recorded here only, no logic depends on it.
    parameter logic [31:0] RESET_PC   = 32'h0000_1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     flush,
    output logic                     ihit,
    output logic [31:0]              instr,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int OFF_W  = offset_bits(LINE_WORDS);
    localparam int IDX_W  = index_bits(NUM_LINES);
    localparam int TAG_W  = tag_bits(NUM_LINES, LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;

    // Elaboration-time sanity checks on the geometry.
    if ((NUM_LINES < 2) || ((NUM_LINES & (NUM_LINES - 1)) != 0)) begin : g_chk_lines
        $error("icache_responder: NUM_LINES must be a power of 2 and at least 2");
    end
    if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_chk_words
        $error("icache_responder: LINE_WORDS must be a power of 2 and at least 2");
    end
    if (TAG_W < 1) begin : g_chk_tag
        $error("icache_responder: geometry leaves no tag bits");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_chk_rpc
        $error("icache_responder: RESET_PC must be word aligned");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_miss_addr;   // line-aligned, drives mem_addr directly
    logic        r_flush_pend;  // flush seen while a refill was in flight

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_rd_vld;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [LINE_W-1:0]   w_rd_line;
    logic [31:0]         w_rd_word;
    logic                w_lookup_hit;
    logic                w_miss;
    logic                w_wr_en;
    logic                w_flush_all;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [TAG_W-1:0]    w_wr_tag;
    logic                w_unused_pc_lsb;

    // Address split of the fetch PC.
    assign w_off = pc[2 +: OFF_W];
    assign w_idx = pc[2 + OFF_W +: IDX_W];
    assign w_tag = pc[31 -: TAG_W];

    // Byte-offset bits never reach the cache.
    assign w_unused_pc_lsb = &{1'b0, pc[1:0]};

    // Refill target comes from the latched miss address, not the live pc,
    // so pc may wander while the request is outstanding.
    assign w_wr_idx = r_miss_addr[2 + OFF_W +: IDX_W];
    assign w_wr_tag = r_miss_addr[31 -: TAG_W];

    icache_tagram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_tagram (
        .clk       (clk),
        .reset     (reset),
        .i_rd_idx  (w_idx),
        .o_rd_vld  (w_rd_vld),
        .o_rd_tag  (w_rd_tag),
        .o_rd_line (w_rd_line),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_tag  (w_wr_tag),
        .i_wr_line (mem_rdata),
        .i_flush   (w_flush_all)
    );

    assign w_lookup_hit = w_rd_vld && (w_rd_tag == w_tag);
    assign w_rd_word    = w_rd_line[{w_off, 5'd0} +: 32];

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ihit        = 1'b0;
        instr       = NOP_INSTR;
        w_miss      = 1'b0;
        w_wr_en     = 1'b0;
        w_flush_all = 1'b0;

        case (r_state)
            LOOKUP: begin
                if (w_lookup_hit) begin
                    ihit  = 1'b1;
                    instr = w_rd_word;
                end else begin
                    w_miss      = 1'b1;
                    w_state_nxt = REFILL;
                end
                // Cleared at the edge; this cycle still answers from the old contents.
                w_flush_all = flush;
            end
            REFILL: begin
                // mem_valid is only meaningful here; anywhere else it is dropped.
                if (mem_valid) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                // Any flush seen during the refill (or right now) lands as we
                // re-enter LOOKUP, wiping the freshly written line as well.
                w_flush_all = r_flush_pend || flush;
                w_state_nxt = LOOKUP;
            end
            default: begin
                w_state_nxt = LOOKUP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register, miss latch, deferred flush
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOOKUP;
            r_miss_addr  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_miss) begin
                r_miss_addr <= {pc[31:2 + OFF_W], {(OFF_W + 2){1'b0}}};
            end

            if (r_state == FILL) begin
                r_flush_pend <= 1'b0;
            end else if ((r_state == REFILL) && flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Straight from the state register so reset drops the request asynchronously.
    assign mem_req  = (r_state == REFILL);
    assign mem_addr = r_miss_addr;

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating hit/miss statistics; flush does not touch them.
    // ------------------------------------------------------------------
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (ihit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder (default geometry: 4 lines x 4 words).
// Reference model is a per-index table of {valid, line base address, line data}
// updated at transaction level; expected values come from that table.
module tb_icache_responder;

    localparam int          NL  = 4;
    localparam int          LW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic              flush;
    logic              ihit;
    logic [31:0]       instr;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_valid;
    logic [LW*32-1:0]  mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    always #5 clk = ~clk;

    icache_responder dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .flush     (flush),
        .ihit      (ihit),
        .instr     (instr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    bit               m_vld  [NL];
    logic [31:0]      m_base [NL];
    logic [LW*32-1:0] m_data [NL];
    int               m_hits   = 0;
    int               m_misses = 0;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % (LW * 4));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / (LW * 4)) % NL);
    endfunction

    function automatic int off_of(input logic [31:0] a);
        return int'((a / 4) % LW);
    endfunction

    // Backing memory contents: a hash of the word address.
    function automatic logic [LW*32-1:0] mem_line(input logic [31:0] base);
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) begin
            l[w*32 +: 32] = ((base + 32'(w * 4)) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    function automatic logic [LW*32-1:0] rnd_line();
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] rnd_pc();
        return 32'h1000 + ($urandom_range(0, 5) << 6) + ($urandom_range(0, 3) << 4)
                        + ($urandom_range(0, 3) << 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
    endtask

    task automatic model_lookup(input logic [31:0] a, output bit h, output logic [31:0] w);
        int i;
        i = idx_of(a);
        h = m_vld[i] && (m_base[i] == line_of(a));
        w = m_data[i][off_of(a)*32 +: 32];
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One LOOKUP cycle presenting address a; optional flush and stray mem_valid.
    task automatic lookup_cycle(input logic [31:0] a, input bit fl, input bit stray, output bit h);
        logic [31:0] w;
        cyc();
        reset     = 1'b0;
        pc        = a;
        flush     = fl;
        mem_valid = stray;
        mem_rdata = rnd_line();
        #1;
        model_lookup(a, h, w);
        chk("lookup_ihit",  {31'd0, ihit},    {31'd0, h});
        chk("lookup_instr", instr,            h ? w : NOP);
        chk("lookup_req",   {31'd0, mem_req}, 32'd0);
        if (h) m_hits++;
        else   m_misses++;
        if (fl) model_clear();
    endtask

    // Called right after a missing lookup_cycle for address a.
    task automatic miss_flow(input logic [31:0] a, input logic [LW*32-1:0] line,
                             input int waits, input int flush_at, input bit fill_flush,
                             input bit wig, input logic [31:0] wpc);
        bit pend;
        int i;
        pend = 1'b0;
        cyc();
        flush     = 1'b0;
        mem_valid = 1'b0;
        if (wig) pc = wpc;
        #1;
        chk("refill_req_rise", {31'd0, mem_req}, 32'd1);
        chk("refill_addr",     mem_addr,         line_of(a));
        chk("refill_ihit",     {31'd0, ihit},    32'd0);
        chk("refill_instr",    instr,            NOP);
        for (int k = 0; k < waits; k++) begin
            cyc();
            flush = (k == flush_at);
            if (flush) pend = 1'b1;
            if (wig) pc = wpc;
            #1;
            chk("wait_req",  {31'd0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr,         line_of(a));
            chk("wait_ihit", {31'd0, ihit},    32'd0);
        end
        cyc();
        flush     = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = line;
        #1;
        chk("valid_req", {31'd0, mem_req}, 32'd1);
        cyc();
        mem_valid = 1'b0;
        mem_rdata = rnd_line();
        flush     = fill_flush;
        #1;
        chk("fill_ihit",  {31'd0, ihit},    32'd0);
        chk("fill_instr", instr,            NOP);
        chk("fill_req",   {31'd0, mem_req}, 32'd0);
        i = idx_of(a);
        m_vld[i]  = 1'b1;
        m_base[i] = line_of(a);
        m_data[i] = line;
        if (pend || fill_flush) model_clear();
    endtask

    task automatic access(input logic [31:0] a);
        bit h;
        lookup_cycle(a, 1'b0, 1'b0, h);
        if (!h) begin
            miss_flow(a, mem_line(line_of(a)), 1, -1, 1'b0, 1'b0, 32'h0);
            lookup_cycle(a, 1'b0, 1'b0, h);
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, "_hits"},   hit_count,  32'(m_hits));
        chk({tag, "_misses"}, miss_count, 32'(m_misses));
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [31:0] a;
        int          waits;
        int          fat;

        model_clear();
        reset     = 1'b1;
        pc        = 32'h1000;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;

        // ---- reset state ----
        cyc();
        cyc();
        chk("reset_ihit",  {31'd0, ihit},    32'd0);
        chk("reset_instr", instr,            NOP);
        chk("reset_req",   {31'd0, mem_req}, 32'd0);
        chk("reset_addr",  mem_addr,         32'd0);
`ifdef ICACHE_STATS_EN
        chk_stats("reset");
`endif

        // ---- cold miss ----
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
        chk("cold_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h1000, {32'h213, 32'h113, 32'h93, 32'h13}, 1, -1, 1'b0, 1'b0, 32'h0);
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
        chk("cold_hit_w0",  {31'd0, ihit}, 32'd1);
        chk("cold_instr_w0", instr, 32'h0000_0013);
        lookup_cycle(32'h100C, 1'b0, 1'b0, h);
        chk("cold_instr_w3", instr, 32'h0000_0213);
        lookup_cycle(32'h1004, 1'b0, 1'b0, h);
        chk("cold_instr_w1", instr, 32'h0000_0093);
`ifdef ICACHE_STATS_EN
        chk("stats_hit3",  hit_count,  32'd3);
        chk("stats_miss1", miss_count, 32'd1);
`endif

        // ---- conflict eviction (same index, different tag) ----
        lookup_cycle(32'h1040, 1'b0, 1'b0, h);
        chk("conflict_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h1040, mem_line(32'h1040), 2, -1, 1'b0, 1'b0, 32'h0);
        lookup_cycle(32'h1040, 1'b0, 1'b0, h);
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
        chk("evicted_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h1000, mem_line(32'h1000), 0, -1, 1'b0, 1'b0, 32'h0);

        // ---- pc change during refill ----
        lookup_cycle(32'h2000, 1'b0, 1'b0, h);
        miss_flow(32'h2000, mem_line(32'h2000), 3, -1, 1'b0, 1'b1, 32'h3000);
        lookup_cycle(32'h3000, 1'b0, 1'b0, h);
        chk("after_wiggle_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h3000, mem_line(32'h3000), 1, -1, 1'b0, 1'b0, 32'h0);

        // ---- flush in LOOKUP ----
        access(32'h1000);
        lookup_cycle(32'h1000, 1'b1, 1'b0, h);
        chk("flush_cycle_still_hits", {31'd0, ihit}, 32'd1);
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
        chk("after_flush_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h1000, mem_line(32'h1000), 1, -1, 1'b0, 1'b0, 32'h0);

        // ---- flush during REFILL ----
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
        lookup_cycle(32'h2010, 1'b0, 1'b0, h);
        miss_flow(32'h2010, mem_line(32'h2010), 3, 0, 1'b0, 1'b0, 32'h0);
        lookup_cycle(32'h2010, 1'b0, 1'b0, h);
        chk("refill_flush_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h2010, mem_line(32'h2010), 1, -1, 1'b0, 1'b0, 32'h0);
        lookup_cycle(32'h2010, 1'b0, 1'b0, h);

        // ---- reset mid-refill, then a stale mem_valid ----
        lookup_cycle(32'h2000, 1'b0, 1'b0, h);
        cyc();
        #1;
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("async_reset_req",   {31'd0, mem_req}, 32'd0);
        chk("async_reset_addr",  mem_addr,         32'd0);
        chk("async_reset_ihit",  {31'd0, ihit},    32'd0);
        chk("async_reset_instr", instr,            NOP);
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        cyc();
        lookup_cycle(32'h1000, 1'b0, 1'b1, h);
        chk("post_reset_miss", {31'd0, ihit}, 32'd0);
        miss_flow(32'h1000, mem_line(32'h1000), 2, -1, 1'b0, 1'b0, 32'h0);
        lookup_cycle(32'h1000, 1'b0, 1'b0, h);
`ifdef ICACHE_STATS_EN
        chk_stats("post_reset");
`endif

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            a = rnd_pc();
            lookup_cycle(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), h);
            if (!h) begin
                waits = $urandom_range(0, 4);
                fat   = -1;
                if ((waits > 0) && ($urandom_range(0, 5) == 0)) fat = $urandom_range(0, waits - 1);
                miss_flow(a, mem_line(line_of(a)), waits, fat,
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1), rnd_pc());
            end
        end
`ifdef ICACHE_STATS_EN
        chk_stats("final");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
